// File: rtl/cfu_cmd_master.sv
// cfu_cmd_master: queues host commands, issues them one at a time to a
// CFU over a valid/ready command channel, and collects each CFU result
// into a response queue that the host drains in order. A watchdog drops
// commands the CFU never answers. Responses that arrive with no command
// outstanding are dropped. Both events are recorded in sticky error bits.
`timescale 1ns/1ps

module cfu_cmd_master #(
   parameter int REQ_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TIMEOUT   = 256
) (
   input  logic        clk,
   input  logic        reset,

   // host command push
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [9:0]  req_function_id,
   input  logic [31:0] req_in0,
   input  logic [31:0] req_in1,

   // host response pop
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,

   // command channel to the CFU
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [9:0]  cmd_payload_function_id,
   output logic [31:0] cmd_payload_inputs_0,
   output logic [31:0] cmd_payload_inputs_1,

   // response channel from the CFU
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [31:0] rsp_payload_outputs_0,

   // status
   output logic        busy,
   output logic        err_timeout,
   output logic        err_stale
);

   localparam int REQ_AW = $clog2(REQ_DEPTH);
   localparam int REQ_CW = REQ_AW + 1;
   localparam int RSP_AW = $clog2(RSP_DEPTH);
   localparam int RSP_CW = RSP_AW + 1;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [REQ_CW-1:0] REQ_FULL_CNT = REQ_CW'(REQ_DEPTH);
   localparam logic [RSP_CW-1:0] RSP_FULL_CNT = RSP_CW'(RSP_DEPTH);
   localparam logic [CNT_W-1:0]  WAIT_LAST    = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // request queue storage and bookkeeping
   logic [9:0]        req_fid_mem [REQ_DEPTH];
   logic [31:0]       req_in0_mem [REQ_DEPTH];
   logic [31:0]       req_in1_mem [REQ_DEPTH];
   logic [REQ_AW-1:0] req_wr_ptr;
   logic [REQ_AW-1:0] req_rd_ptr;
   logic [REQ_CW-1:0] req_count;
   logic              req_push;
   logic              req_pop;
   logic              req_empty;
   logic              req_full;

   // response queue storage and bookkeeping
   logic [31:0]       rsp_data_mem [RSP_DEPTH];
   logic [RSP_AW-1:0] rsp_wr_ptr;
   logic [RSP_AW-1:0] rsp_rd_ptr;
   logic [RSP_CW-1:0] rsp_count;
   logic              rsp_push;
   logic              rsp_pop;
   logic              rsp_empty;
   logic              rsp_full;

   // sequencing
   logic [CNT_W-1:0]  wait_cnt;
   logic              issue;
   logic              cmd_hs;
   logic              rsp_hs;
   logic              timeout_hit;
   logic              stale_hit;

   assign req_empty = (req_count == '0);
   assign req_full  = (req_count == REQ_FULL_CNT);
   assign rsp_empty = (rsp_count == '0);
   assign rsp_full  = (rsp_count == RSP_FULL_CNT);

   // Ready depends only on occupancy, so a pop on the same edge never
   // opens the queue early.
   assign req_ready = !req_full;
   assign req_push  = req_valid && !req_full;

   // A command leaves the queue only when the response queue has a free
   // slot. Because a single command is ever outstanding, that slot stays
   // reserved for its result and the response queue cannot overflow.
   assign issue   = (state == IDLE) && !req_empty && !rsp_full;
   assign req_pop = issue;

   // Handshake outputs are forced low while reset is held.
   assign cmd_valid = (state == ISSUE) && !reset;
   assign rsp_ready = (state != ISSUE) && !reset;
   assign res_valid = !rsp_empty && !reset;
   assign busy      = !reset && ((state != IDLE) || !req_empty);

   assign cmd_hs   = cmd_valid && cmd_ready;
   assign rsp_hs   = rsp_valid && rsp_ready;
   assign rsp_push = rsp_hs && (state == WAIT);
   assign rsp_pop  = res_valid && res_ready;

   // A response that arrives on the last allowed WAIT cycle still wins.
   assign timeout_hit = (state == WAIT) && !rsp_hs && (wait_cnt == WAIT_LAST);
   assign stale_hit   = rsp_hs && (state == IDLE);

   assign res_data = rsp_data_mem[rsp_rd_ptr];

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = ISSUE;
         ISSUE:   if (cmd_hs) state_nxt = WAIT;
         WAIT:    if (rsp_hs || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request queue entry write
   always_ff @(posedge clk) begin
      if (req_push) begin
         req_fid_mem[req_wr_ptr] <= req_function_id;
         req_in0_mem[req_wr_ptr] <= req_in0;
         req_in1_mem[req_wr_ptr] <= req_in1;
      end
   end

   // Request queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         req_wr_ptr <= '0;
         req_rd_ptr <= '0;
         req_count  <= '0;
      end else begin
         if (req_push) req_wr_ptr <= req_wr_ptr + REQ_AW'(1);
         if (req_pop)  req_rd_ptr <= req_rd_ptr + REQ_AW'(1);
         case ({req_push, req_pop})
            2'b10:   req_count <= req_count + REQ_CW'(1);
            2'b01:   req_count <= req_count - REQ_CW'(1);
            default: req_count <= req_count;
         endcase
      end
   end

   // Command registers: loaded from the queue head when a command issues
   // and held unchanged until the CFU accepts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_payload_function_id <= '0;
         cmd_payload_inputs_0    <= '0;
         cmd_payload_inputs_1    <= '0;
      end else if (issue) begin
         cmd_payload_function_id <= req_fid_mem[req_rd_ptr];
         cmd_payload_inputs_0    <= req_in0_mem[req_rd_ptr];
         cmd_payload_inputs_1    <= req_in1_mem[req_rd_ptr];
      end
   end

   // WAIT watchdog: counts cycles spent waiting and restarts from zero on
   // every entry into WAIT.
   always_ff @(posedge clk) begin
      if (reset || (state != WAIT)) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Response queue entry write
   always_ff @(posedge clk) begin
      if (rsp_push) begin
         rsp_data_mem[rsp_wr_ptr] <= rsp_payload_outputs_0;
      end
   end

   // Response queue pointers and occupancy; a push and a pop on the same
   // edge both happen and leave the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_wr_ptr <= '0;
         rsp_rd_ptr <= '0;
         rsp_count  <= '0;
      end else begin
         if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RSP_AW'(1);
         if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RSP_AW'(1);
         case ({rsp_push, rsp_pop})
            2'b10:   rsp_count <= rsp_count + RSP_CW'(1);
            2'b01:   rsp_count <= rsp_count - RSP_CW'(1);
            default: rsp_count <= rsp_count;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         err_timeout <= 1'b0;
         err_stale   <= 1'b0;
      end else begin
         if (timeout_hit) err_timeout <= 1'b1;
         if (stale_hit)   err_stale   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cfu_cmd_master.sv
// Testbench for cfu_cmd_master: directed host requests with hand-written
// CFU results, a behavioural CFU that checks every command it accepts,
// and a response monitor that pops expected results from a scoreboard.
`timescale 1ns/1ps

module tb_cfu_cmd_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_function_id;
   logic [31:0] req_in0;
   logic [31:0] req_in1;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   logic        busy;
   logic        err_timeout;
   logic        err_stale;

   int n_chk  = 0;
   int n_fail = 0;

   // scoreboards
   logic [73:0] exp_cmd_q[$];
   logic [31:0] cfu_q[$];
   logic [31:0] exp_res_q[$];

   // CFU model controls (written by the stimulus thread only)
   bit cfu_auto   = 1'b1;
   int cfu_lat    = 3;
   int stale_reqs = 0;

   logic [31:0] t3_rsp [8] = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004,
                               32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007, 32'hC0DE0008};

   cfu_cmd_master #(.REQ_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(256)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_function_id         (req_function_id),
      .req_in0                 (req_in0),
      .req_in1                 (req_in1),
      .res_valid               (res_valid),
      .res_ready               (res_ready),
      .res_data                (res_data),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (cmd_payload_function_id),
      .cmd_payload_inputs_0    (cmd_payload_inputs_0),
      .cmd_payload_inputs_1    (cmd_payload_inputs_1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_payload_outputs_0),
      .busy                    (busy),
      .err_timeout             (err_timeout),
      .err_stale               (err_stale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one request and hold it until accepted; returns 1ns after the
   // accepting edge.
   task automatic push_req(input logic [9:0] fid, input logic [31:0] in0,
                           input logic [31:0] in1, input logic [31:0] rsp,
                           input bit expect_rsp);
      int budget;
      budget = 600;
      req_valid = 1'b1;
      req_function_id = fid;
      req_in0 = in0;
      req_in1 = in1;
      while (budget > 0) begin
         @(negedge clk);
         if (req_ready) break;
         budget--;
      end
      chk("req_accept_in_time", (budget > 0), 1'b1);
      if (budget > 0) begin
         exp_cmd_q.push_back({fid, in0, in1});
         if (expect_rsp) begin
            cfu_q.push_back(rsp);
            exp_res_q.push_back(rsp);
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_cmd_hs(input int budget);
      int k;
      k = 0;
      while (k < budget) begin
         @(negedge clk);
         if (cmd_valid && cmd_ready) break;
         k++;
      end
      chk("cmd_hs_in_time", (k < budget), 1'b1);
      @(posedge clk);
      #1;
   endtask

   // Waits for a CFU response handshake; with pop_too the host pops the
   // response queue on that same edge.
   task automatic wait_rsp_hs(input int budget, input bit pop_too);
      int k;
      k = 0;
      while (k < budget) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) break;
         k++;
      end
      chk("rsp_hs_in_time", (k < budget), 1'b1);
      if (pop_too) res_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_res_q.size() != 0 || busy) && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, (k < budget), 1'b1);
   endtask

   // Response monitor: every host pop must match the oldest expected result.
   initial begin : res_monitor
      forever begin
         @(negedge clk);
         #2;
         if (!reset && res_valid && res_ready) begin
            if (exp_res_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL res_extra: got 0x%0h, no response was expected", res_data);
            end else begin
               chk("res_data", res_data, exp_res_q.pop_front());
            end
         end
      end
   end

   // Behavioural CFU: checks accepted commands, answers after cfu_lat cycles.
   initial begin : cfu_model
      bit          pending;
      int          cnt;
      int          stale_done;
      logic [31:0] val;
      logic        cmd_hs_s;
      logic        rsp_hs_s;
      logic [73:0] cmd_s;
      pending = 1'b0;
      cnt = 0;
      stale_done = 0;
      val = '0;
      rsp_valid = 1'b0;
      rsp_payload_outputs_0 = '0;
      forever begin
         @(negedge clk);
         cmd_hs_s = !reset && cmd_valid && cmd_ready;
         rsp_hs_s = !reset && rsp_valid && rsp_ready;
         cmd_s = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
         @(posedge clk);
         #1;
         if (rsp_hs_s) rsp_valid = 1'b0;
         if (cmd_hs_s) begin
            if (exp_cmd_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL cmd_extra: got 0x%0h, no command was expected", cmd_s);
            end else begin
               chk("cmd_payload", cmd_s, exp_cmd_q.pop_front());
            end
            if (cfu_auto && cfu_q.size() != 0) begin
               pending = 1'b1;
               cnt = cfu_lat;
               val = cfu_q.pop_front();
            end
         end
         if (pending) begin
            if (cnt == 0) begin
               rsp_valid = 1'b1;
               rsp_payload_outputs_0 = val;
               pending = 1'b0;
            end else begin
               cnt--;
            end
         end
         if (stale_reqs != stale_done) begin
            rsp_valid = 1'b1;
            rsp_payload_outputs_0 = 32'hDEADBEEF;
            stale_done++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b1;
      req_valid = 1'b0;
      req_function_id = '0;
      req_in0 = '0;
      req_in1 = '0;
      res_ready = 1'b0;
      cmd_ready = 1'b0;

      // reset state
      tick(2);
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_rsp_ready", rsp_ready, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err_timeout", err_timeout, 1'b0);
      chk("rst_err_stale", err_stale, 1'b0);
      chk("rst_fid", cmd_payload_function_id, 10'h000);
      chk("rst_in0", cmd_payload_inputs_0, 32'h0);
      chk("rst_in1", cmd_payload_inputs_1, 32'h0);
      reset = 1'b0;
      tick(1);
      chk("idle_rsp_ready", rsp_ready, 1'b1);
      chk("idle_req_ready", req_ready, 1'b1);

      // single command, latency and response path
      cmd_ready = 1'b1;
      cfu_lat = 3;
      push_req(10'h009, 32'h01020304, 32'h05060708, 32'h0000002A, 1'b1);
      chk("t1_cmd_valid_edgeN", cmd_valid, 1'b0);
      chk("t1_busy", busy, 1'b1);
      tick(1);
      chk("t1_cmd_valid_edgeN1", cmd_valid, 1'b1);
      chk("t1_fid", cmd_payload_function_id, 10'h009);
      chk("t1_in0", cmd_payload_inputs_0, 32'h01020304);
      chk("t1_in1", cmd_payload_inputs_1, 32'h05060708);
      wait_rsp_hs(20, 1'b0);
      chk("t1_res_valid", res_valid, 1'b1);
      chk("t1_res_data", res_data, 32'h0000002A);
      chk("t1_err_timeout", err_timeout, 1'b0);
      chk("t1_err_stale", err_stale, 1'b0);
      res_ready = 1'b1;
      wait_drain("t1_drain", 50);

      // command back-pressure
      cmd_ready = 1'b0;
      cfu_lat = 2;
      push_req(10'h011, 32'hAAAA0001, 32'hBBBB0002, 32'h12345678, 1'b1);
      tick(1);
      for (int i = 0; i < 10; i++) begin
         chk("t2_cmd_held", cmd_valid, 1'b1);
         chk("t2_payload_stable",
             {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1},
             {10'h011, 32'hAAAA0001, 32'hBBBB0002});
         chk("t2_rsp_ready_issue", rsp_ready, 1'b0);
         tick(1);
      end
      cmd_ready = 1'b1;
      tick(1);
      chk("t2_cmd_dropped", cmd_valid, 1'b0);
      wait_drain("t2_drain", 50);

      // both queues full while the host does not pop
      res_ready = 1'b0;
      cfu_lat = 1;
      for (int i = 0; i < 8; i++) begin
         push_req(10'h101 + 10'(i), 32'h10000000 + 32'(i), 32'h20000000 + 32'(i),
                  t3_rsp[i], 1'b1);
      end
      tick(20);
      chk("t3_req_ready_full", req_ready, 1'b0);
      chk("t3_no_issue", cmd_valid, 1'b0);
      chk("t3_res_valid", res_valid, 1'b1);
      chk("t3_res_head", res_data, 32'hC0DE0001);
      chk("t3_busy", busy, 1'b1);
      req_valid = 1'b1;
      req_function_id = 10'h3FF;
      req_in0 = 32'hFFFFFFFF;
      req_in1 = 32'hFFFFFFFF;
      tick(3);
      chk("t3_req_blocked", req_ready, 1'b0);
      req_valid = 1'b0;
      res_ready = 1'b1;
      wait_drain("t3_drain", 200);

      // CFU never answers: watchdog, then a late stale response
      cfu_auto = 1'b0;
      push_req(10'h022, 32'h0BADF00D, 32'h00000001, 32'h0, 1'b0);
      wait_cmd_hs(20);
      tick(255);
      chk("t4_no_timeout_yet", err_timeout, 1'b0);
      chk("t4_busy_waiting", busy, 1'b1);
      tick(1);
      chk("t4_err_timeout", err_timeout, 1'b1);
      chk("t4_idle_after", busy, 1'b0);
      chk("t4_no_stale_yet", err_stale, 1'b0);
      stale_reqs++;
      tick(4);
      chk("t4_err_stale", err_stale, 1'b1);
      chk("t4_stale_dropped", res_valid, 1'b0);
      chk("t4_timeout_sticky", err_timeout, 1'b1);

      // reset in the middle of WAIT
      push_req(10'h033, 32'h0000CAFE, 32'h0000BEEF, 32'h0, 1'b0);
      wait_cmd_hs(20);
      tick(5);
      chk("t5_busy_pre", busy, 1'b1);
      reset = 1'b1;
      tick(1);
      chk("t5_cmd_valid", cmd_valid, 1'b0);
      chk("t5_rsp_ready", rsp_ready, 1'b0);
      chk("t5_res_valid", res_valid, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_err_timeout", err_timeout, 1'b0);
      chk("t5_err_stale", err_stale, 1'b0);
      chk("t5_payload",
          {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, 74'h0);
      reset = 1'b0;
      cfu_auto = 1'b1;
      cfu_lat = 1;
      push_req(10'h044, 32'h00000005, 32'h00000006, 32'h5A5A0044, 1'b1);
      wait_drain("t5_drain", 50);
      chk("t5_err_timeout_after", err_timeout, 1'b0);

      // response push and host pop on the same edge
      res_ready = 1'b0;
      cfu_lat = 0;
      push_req(10'h055, 32'h000000A0, 32'h000000A1, 32'h000000A1, 1'b1);
      wait_rsp_hs(20, 1'b0);
      chk("t6_one_queued", res_valid, 1'b1);
      cfu_lat = 3;
      push_req(10'h066, 32'h000000B0, 32'h000000B1, 32'h000000B2, 1'b1);
      wait_rsp_hs(30, 1'b1);
      res_ready = 1'b0;
      chk("t6_count_kept", res_valid, 1'b1);
      chk("t6_order", res_data, 32'h000000B2);
      tick(2);
      chk("t6_still_one", res_valid, 1'b1);
      chk("t6_idle", busy, 1'b0);
      res_ready = 1'b1;
      wait_drain("t6_drain", 50);
      tick(2);
      chk("t6_empty", res_valid, 1'b0);

      chk("cmd_scoreboard_empty", exp_cmd_q.size(), 0);
      chk("res_scoreboard_empty", exp_res_q.size(), 0);
      chk("final_err_stale", err_stale, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
